pc_ir_fetch_unit: RTL

//   Datapath front end for the multicycle CPU. Owns the PC and the instruction

---
 rtl/pc_ir_fetch_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_ir_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ir_fetch_unit
// Description : Datapath front end for the multicycle CPU. Holds the program
//               counter and the instruction register, fetches instruction
//               words over a req/ack memory handshake and presents the opcode
//               field to the control unit.
//               Optional feature macro: PCU_FETCH_TIMEOUT_EN. When defined,
//               an outstanding fetch is abandoned after TIMEOUT_CYCLES cycles
//               without ack and a sticky fetch_err flag is raised.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ir_fetch_unit #(
   parameter int               WIDTH          = 32,
   parameter logic [WIDTH-1:0] RESET_PC       = '0,
   parameter int               TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IRWrite,
   input  logic             PCWrite,
   input  logic             PCWriteCond,
   input  logic [1:0]       PCSource,
   input  logic             zero,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] instr,
   output logic [5:0]       opCode,
   output logic             ir_valid,
   output logic             fetch_busy,
   output logic             fetch_err
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_WAIT = 1'b1;

   // Bits of the PC that survive a jump (everything above bit 27).
   localparam logic [WIDTH-1:0] c_HI_MASK    = ~WIDTH'(28'hFFF_FFFF);
   // Instruction addresses are word aligned; the low two bits are never set.
   localparam logic [WIDTH-1:0] c_ALIGN_MASK = ~WIDTH'(2'b11);

   // -------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // -------------------------------------------------------------------------
   generate
      if (WIDTH < 28) begin : g_bad_width
         $error("pc_ir_fetch_unit: WIDTH must be at least 28");
      end
      if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
         $error("pc_ir_fetch_unit: RESET_PC must be word aligned");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("pc_ir_fetch_unit: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Registers and wires
   // -------------------------------------------------------------------------
   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_instr;
   logic             r_mem_req;
   logic [WIDTH-1:0] r_mem_addr;
   logic             r_ir_valid;

   logic             w_in_wait;
   logic             w_fetch_start;
   logic             w_fetch_done;
   logic             w_timeout;
   logic             w_pc_we;
   logic [WIDTH-1:0] w_jump_target;
   logic [WIDTH-1:0] w_pc_src;
   logic [WIDTH-1:0] w_pc_next;

   // -------------------------------------------------------------------------
   // Fetch handshake decode
   // -------------------------------------------------------------------------
   // IRWrite is only honoured from IDLE; a request arriving while a fetch is
   // outstanding is dropped rather than queued. An ack seen in IDLE is stray
   // (e.g. the tail of a fetch aborted by reset) and must not touch the IR.
   assign w_in_wait     = (r_state == c_ST_WAIT);
   assign w_fetch_start = (r_state == c_ST_IDLE) && IRWrite;
   assign w_fetch_done  = w_in_wait && mem_ack;

`ifdef PCU_FETCH_TIMEOUT_EN
   // -------------------------------------------------------------------------
   // Optional fetch timeout
   // -------------------------------------------------------------------------
   localparam int               c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

   logic [c_TMO_W-1:0] r_timer;
   logic               r_fetch_err;

   // The timer counts WAIT cycles that pass without an ack; the cycle that
   // would be number TIMEOUT_CYCLES abandons the fetch instead.
   assign w_timeout = w_in_wait && !mem_ack && (r_timer == c_TMO_LAST);

   // Wait-cycle counter, cleared whenever a new fetch is launched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
      end else if (w_fetch_start) begin
         r_timer <= '0;
      end else if (w_in_wait && !mem_ack && !w_timeout) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Sticky error flag; only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_err <= 1'b0;
      end else if (w_timeout) begin
         r_fetch_err <= 1'b1;
      end
   end

   assign fetch_err = r_fetch_err;
`else
   // Without the timeout a fetch waits for its ack indefinitely.
   assign w_timeout = 1'b0;
   assign fetch_err = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next-PC selection
   // -------------------------------------------------------------------------
   assign w_pc_we       = PCWrite || (PCWriteCond && zero);
   // Jump target keeps the PC's upper region and takes the 26-bit word
   // index from the instruction currently held in the IR.
   assign w_jump_target = (r_pc & c_HI_MASK) | WIDTH'({r_instr[25:0], 2'b00});

   // Choose the next-PC source selected by the control unit.
   always_comb begin
      w_pc_src = r_pc;
      case (PCSource)
         2'b00:   w_pc_src = alu_result;
         2'b01:   w_pc_src = alu_out;
         2'b10:   w_pc_src = w_jump_target;
         default: w_pc_src = r_pc;
      endcase
   end

   // Externally supplied addresses may carry low bits; strip them.
   assign w_pc_next = w_pc_src & c_ALIGN_MASK;

   // Program counter; may be rewritten while a fetch is outstanding because
   // the fetch uses its own latched address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else if (w_pc_we) begin
         r_pc <= w_pc_next;
      end
   end

   // -------------------------------------------------------------------------
   // Fetch state machine and memory request
   // -------------------------------------------------------------------------
   // Two-state fetch controller; request and address are held until the
   // fetch completes (or times out).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= c_ST_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_fetch_start) begin
                  r_state    <= c_ST_WAIT;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= r_pc;
               end
            end
            c_ST_WAIT: begin
               if (w_fetch_done || w_timeout) begin
                  r_state   <= c_ST_IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= c_ST_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Instruction register
   // -------------------------------------------------------------------------
   // Capture the returned word and pulse ir_valid for exactly one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr    <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         r_ir_valid <= w_fetch_done;
         if (w_fetch_done) begin
            r_instr <= mem_rdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign pc         = r_pc;
   assign instr      = r_instr;
   // Opcode is the top six IR bits (instr[31:26] at the default width).
   assign opCode     = r_instr[WIDTH-1 -: 6];
   assign ir_valid   = r_ir_valid;
   assign fetch_busy = w_in_wait;

endmodule
`default_nettype wire
